// File: rtl/lsu_axi_pkg.sv
// Shared definitions for the AXI4 load/store unit: op codes, AXI field widths
// and constants, FSM state type and small op-decoding helpers.
package lsu_axi_pkg;

   localparam int unsigned LSU_OP_W = 4;

   localparam logic [LSU_OP_W-1:0] LSU_OP_LB  = 4'h0;
   localparam logic [LSU_OP_W-1:0] LSU_OP_LBU = 4'h1;
   localparam logic [LSU_OP_W-1:0] LSU_OP_LH  = 4'h2;
   localparam logic [LSU_OP_W-1:0] LSU_OP_LHU = 4'h3;
   localparam logic [LSU_OP_W-1:0] LSU_OP_LW  = 4'h4;
   localparam logic [LSU_OP_W-1:0] LSU_OP_SB  = 4'h8;
   localparam logic [LSU_OP_W-1:0] LSU_OP_SH  = 4'h9;
   localparam logic [LSU_OP_W-1:0] LSU_OP_SW  = 4'hA;

   localparam int unsigned AXI_LEN_W   = 8;
   localparam int unsigned AXI_SIZE_W  = 3;
   localparam int unsigned AXI_BURST_W = 2;
   localparam int unsigned AXI_RESP_W  = 2;

   localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RESP
   } lsu_state_e;

   // log2 of the access size in bytes: 0 = byte, 1 = half, 2 = word
   function automatic logic [1:0] op_size(input logic [LSU_OP_W-1:0] op);
      case (op)
         LSU_OP_LB, LSU_OP_LBU, LSU_OP_SB: op_size = 2'd0;
         LSU_OP_LH, LSU_OP_LHU, LSU_OP_SH: op_size = 2'd1;
         default:                          op_size = 2'd2;
      endcase
   endfunction

   function automatic logic op_is_store(input logic [LSU_OP_W-1:0] op);
      op_is_store = op[3];
   endfunction

   function automatic logic op_is_signed(input logic [LSU_OP_W-1:0] op);
      op_is_signed = (op == LSU_OP_LB) || (op == LSU_OP_LH);
   endfunction

   function automatic logic op_misaligned(input logic [LSU_OP_W-1:0] op,
                                          input logic [1:0]          addr_lo);
      case (op_size(op))
         2'd1:    op_misaligned = addr_lo[0];
         2'd2:    op_misaligned = (addr_lo != 2'b00);
         default: op_misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_axi_lane_align.sv
// Byte-lane steering between the register file view and the AXI data bus:
// store strobes/data shifted into place, load data shifted down and extended.
module lsu_lane_align
   import lsu_axi_pkg::*;
#(
   parameter  int unsigned DATA_W = 64,
   parameter  int unsigned XLEN   = 32,
   localparam int unsigned STRB_W = DATA_W / 8,
   localparam int unsigned LANE_W = $clog2(STRB_W)
) (
   input  logic [LSU_OP_W-1:0] op_i,
   input  logic [LANE_W-1:0]   lane_i,
   input  logic [XLEN-1:0]     st_data_i,
   input  logic [DATA_W-1:0]   rdata_i,
   output logic [STRB_W-1:0]   wstrb_o,
   output logic [DATA_W-1:0]   wdata_o,
   output logic [XLEN-1:0]     ld_data_o
);

   logic [1:0]        size;
   logic [LANE_W+2:0] shamt;
   logic [STRB_W-1:0] strb_base;
   logic [31:0]       st_masked;
   logic [31:0]       rd_word;

   assign size  = op_size(op_i);
   assign shamt = {lane_i, 3'b000};

   always_comb begin
      strb_base = '0;
      st_masked = '0;
      case (size)
         2'd0: begin
            strb_base[0]   = 1'b1;
            st_masked[7:0] = st_data_i[7:0];
         end
         2'd1: begin
            strb_base[1:0]  = '1;
            st_masked[15:0] = st_data_i[15:0];
         end
         default: begin
            strb_base[3:0] = '1;
            st_masked      = st_data_i[31:0];
         end
      endcase
   end

   assign wstrb_o = strb_base << lane_i;
   assign wdata_o = DATA_W'(st_masked) << shamt;
   assign rd_word = 32'(rdata_i >> shamt);

   always_comb begin
      ld_data_o = '0;
      case (size)
         2'd0: ld_data_o = op_is_signed(op_i) ? {{(XLEN-8){rd_word[7]}}, rd_word[7:0]}
                                              : XLEN'(rd_word[7:0]);
         2'd1: ld_data_o = op_is_signed(op_i) ? {{(XLEN-16){rd_word[15]}}, rd_word[15:0]}
                                              : XLEN'(rd_word[15:0]);
         default: ld_data_o = XLEN'(rd_word);
      endcase
   end

endmodule

// File: rtl/lsu_axi.sv
// Single-outstanding AXI4 load/store unit: one EXU request at a time, single-beat
// AXI transaction, registered response to the WBU with an error flag.
module lsu_axi
   import lsu_axi_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ID_W   = 4,
   parameter int unsigned AXI_ID = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [LSU_OP_W-1:0]    req_op,
   input  logic [XLEN-1:0]        req_addr,
   input  logic [XLEN-1:0]        req_wdata,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [XLEN-1:0]        resp_data,
   output logic                   resp_err,
   output logic                   awvalid,
   input  logic                   awready,
   output logic [XLEN-1:0]        awaddr,
   output logic [ID_W-1:0]        awid,
   output logic [AXI_LEN_W-1:0]   awlen,
   output logic [AXI_SIZE_W-1:0]  awsize,
   output logic [AXI_BURST_W-1:0] awburst,
   output logic                   wvalid,
   input  logic                   wready,
   output logic [DATA_W-1:0]      wdata,
   output logic [DATA_W/8-1:0]    wstrb,
   output logic                   wlast,
   input  logic                   bvalid,
   output logic                   bready,
   input  logic [AXI_RESP_W-1:0]  bresp,
   input  logic [ID_W-1:0]        bid,
   output logic                   arvalid,
   input  logic                   arready,
   output logic [XLEN-1:0]        araddr,
   output logic [ID_W-1:0]        arid,
   output logic [AXI_LEN_W-1:0]   arlen,
   output logic [AXI_SIZE_W-1:0]  arsize,
   output logic [AXI_BURST_W-1:0] arburst,
   input  logic                   rvalid,
   output logic                   rready,
   input  logic [DATA_W-1:0]      rdata,
   input  logic [AXI_RESP_W-1:0]  rresp,
   input  logic                   rlast,
   input  logic [ID_W-1:0]        rid
);

   localparam int unsigned LANE_W = $clog2(DATA_W / 8);

   lsu_state_e          state_q, state_d;
   logic [LSU_OP_W-1:0] op_q, op_d;
   logic [XLEN-1:0]     addr_q, addr_d;
   logic [XLEN-1:0]     st_data_q, st_data_d;
   logic                aw_done_q, aw_done_d;
   logic                w_done_q, w_done_d;
   logic [XLEN-1:0]     resp_data_q, resp_data_d;
   logic                resp_err_q, resp_err_d;
   logic [XLEN-1:0]     ld_data;
   logic                unused_inputs;

   assign unused_inputs = ^{bid, rid, rlast};

   lsu_lane_align #(.DATA_W(DATA_W), .XLEN(XLEN)) u_align (
      .op_i      (op_q),
      .lane_i    (addr_q[LANE_W-1:0]),
      .st_data_i (st_data_q),
      .rdata_i   (rdata),
      .wstrb_o   (wstrb),
      .wdata_o   (wdata),
      .ld_data_o (ld_data)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         addr_q      <= '0;
         st_data_q   <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         st_data_q   <= st_data_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      st_data_d   = st_data_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d        = req_op;
               addr_d      = req_addr;
               st_data_d   = req_wdata;
               aw_done_d   = 1'b0;
               w_done_d    = 1'b0;
               resp_data_d = '0;
               resp_err_d  = 1'b0;
               if (op_misaligned(req_op, req_addr[1:0])) begin
                  resp_err_d = 1'b1;
                  state_d    = ST_RESP;
               end else if (op_is_store(req_op)) begin
                  state_d = ST_WR_REQ;
               end else begin
                  state_d = ST_RD_ADDR;
               end
            end
         end
         ST_RD_ADDR: begin
            if (arready) state_d = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            if (rvalid) begin
               resp_err_d  = (rresp != AXI_RESP_OKAY);
               resp_data_d = (rresp != AXI_RESP_OKAY) ? '0 : ld_data;
               state_d     = ST_RESP;
            end
         end
         ST_WR_REQ: begin
            // AW and W complete independently; leave once both have handshaken
            if (awready) aw_done_d = 1'b1;
            if (wready)  w_done_d  = 1'b1;
            if ((aw_done_q || awready) && (w_done_q || wready)) state_d = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            if (bvalid) begin
               resp_err_d = (bresp != AXI_RESP_OKAY);
               state_d    = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;

   assign awvalid = (state_q == ST_WR_REQ) && !aw_done_q;
   assign wvalid  = (state_q == ST_WR_REQ) && !w_done_q;
   assign bready  = (state_q == ST_WR_RESP);
   assign arvalid = (state_q == ST_RD_ADDR);
   assign rready  = (state_q == ST_RD_DATA);

   assign awaddr  = addr_q;
   assign araddr  = addr_q;
   assign awid    = ID_W'(AXI_ID);
   assign arid    = ID_W'(AXI_ID);
   assign awlen   = '0;
   assign arlen   = '0;
   assign awsize  = {1'b0, op_size(op_q)};
   assign arsize  = {1'b0, op_size(op_q)};
   assign awburst = AXI_BURST_INCR;
   assign arburst = AXI_BURST_INCR;
   assign wlast   = 1'b1;

endmodule

// File: tb/tb_lsu_axi.sv
// Directed bench for lsu_axi (DATA_W=64): the bench plays EXU, WBU and AXI slave.
module tb_lsu_axi;
   import lsu_axi_pkg::*;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned ID_W   = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic              req_valid, req_ready;
   logic [3:0]        req_op;
   logic [XLEN-1:0]   req_addr, req_wdata;
   logic              resp_valid, resp_ready;
   logic [XLEN-1:0]   resp_data;
   logic              resp_err;
   logic              awvalid, awready;
   logic [XLEN-1:0]   awaddr;
   logic [ID_W-1:0]   awid;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              wvalid, wready;
   logic [DATA_W-1:0] wdata;
   logic [7:0]        wstrb;
   logic              wlast;
   logic              bvalid, bready;
   logic [1:0]        bresp;
   logic [ID_W-1:0]   bid;
   logic              arvalid, arready;
   logic [XLEN-1:0]   araddr;
   logic [ID_W-1:0]   arid;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              rvalid, rready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic [ID_W-1:0]   rid;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clock = ~clock;

   lsu_axi #(.DATA_W(DATA_W), .XLEN(XLEN), .ID_W(ID_W), .AXI_ID(0)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
      .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
      .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs;
      req_valid = 0; req_op = '0; req_addr = '0; req_wdata = '0; resp_ready = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = '0; bid = '0;
      arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0; rid = '0;
   endtask

   task automatic do_reset;
      idle_inputs();
      reset = 1;
      tick();
      reset = 0;
      tick();
   endtask

   task automatic test_reset;
      idle_inputs();
      reset = 1;
      tick();
      tick();
      reset = 0;
      tick();
      tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
      tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
      tests_run++; if (resp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
      tests_run++; if (resp_data !== 32'h0) begin tests_failed++; $display("FAIL reset_resp_data got %h want 0", resp_data); end
      tests_run++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
         tests_failed++; $display("FAIL reset_axi_valids got %b want 00000", {arvalid, awvalid, wvalid, rready, bready}); end
   endtask

   task automatic test_store(input string nm, input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] data, input logic [7:0] exp_strb,
                             input logic [63:0] exp_wdata, input logic [2:0] exp_size);
      do_reset();
      req_valid = 1; req_op = op; req_addr = addr; req_wdata = data;
      tick();
      req_valid = 0;
      tests_run++; if ({awvalid, wvalid} !== 2'b11) begin tests_failed++; $display("FAIL %s aw_w_valid got %b want 11", nm, {awvalid, wvalid}); end
      tests_run++; if (wstrb !== exp_strb) begin tests_failed++; $display("FAIL %s wstrb got %h want %h", nm, wstrb, exp_strb); end
      tests_run++; if (wdata !== exp_wdata) begin tests_failed++; $display("FAIL %s wdata got %h want %h", nm, wdata, exp_wdata); end
      tests_run++; if (awaddr !== addr) begin tests_failed++; $display("FAIL %s awaddr got %h want %h", nm, awaddr, addr); end
      tests_run++; if ({awsize, awlen, awburst, wlast} !== {exp_size, 8'h00, 2'b01, 1'b1}) begin
         tests_failed++; $display("FAIL %s aw_fields got %h/%h/%h/%b want %h/00/1/1", nm, awsize, awlen, awburst, wlast, exp_size); end
      awready = 1; wready = 1;
      tick();
      awready = 0; wready = 0;
      tests_run++; if ({bready, awvalid, wvalid} !== 3'b100) begin tests_failed++; $display("FAIL %s b_phase got %b want 100", nm, {bready, awvalid, wvalid}); end
      bvalid = 1; bresp = 2'b00;
      tick();
      bvalid = 0;
      tests_run++; if (resp_valid !== 1'b1) begin tests_failed++; $display("FAIL %s resp_valid_cycle3 got %b want 1", nm, resp_valid); end
      tests_run++; if ({resp_err, resp_data} !== 33'h0) begin tests_failed++; $display("FAIL %s resp got err=%b data=%h want 0/0", nm, resp_err, resp_data); end
      resp_ready = 1;
      tick();
      resp_ready = 0;
      tests_run++; if ({req_ready, resp_valid} !== 2'b10) begin tests_failed++; $display("FAIL %s after_resp got %b want 10", nm, {req_ready, resp_valid}); end
   endtask

   task automatic test_load(input string nm, input logic [3:0] op, input logic [31:0] addr,
                            input logic [63:0] rd, input logic [1:0] rr, input logic [2:0] exp_size,
                            input logic [31:0] exp_data, input logic exp_err);
      do_reset();
      req_valid = 1; req_op = op; req_addr = addr;
      tick();
      req_valid = 0;
      tests_run++; if (arvalid !== 1'b1) begin tests_failed++; $display("FAIL %s arvalid_cycle1 got %b want 1", nm, arvalid); end
      tests_run++; if (araddr !== addr) begin tests_failed++; $display("FAIL %s araddr got %h want %h", nm, araddr, addr); end
      tests_run++; if ({arsize, arlen, arburst} !== {exp_size, 8'h00, 2'b01}) begin
         tests_failed++; $display("FAIL %s ar_fields got %h/%h/%h want %h/00/1", nm, arsize, arlen, arburst, exp_size); end
      arready = 1;
      tick();
      arready = 0;
      tests_run++; if ({rready, arvalid} !== 2'b10) begin tests_failed++; $display("FAIL %s r_phase got %b want 10", nm, {rready, arvalid}); end
      rvalid = 1; rdata = rd; rresp = rr; rlast = 1;
      tick();
      rvalid = 0; rdata = '0; rresp = '0; rlast = 0;
      tests_run++; if (resp_valid !== 1'b1) begin tests_failed++; $display("FAIL %s resp_valid_cycle3 got %b want 1", nm, resp_valid); end
      tests_run++; if (resp_data !== exp_data) begin tests_failed++; $display("FAIL %s resp_data got %h want %h", nm, resp_data, exp_data); end
      tests_run++; if (resp_err !== exp_err) begin tests_failed++; $display("FAIL %s resp_err got %b want %b", nm, resp_err, exp_err); end
      resp_ready = 1;
      tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL %s no_bypass got %b want 0", nm, req_ready); end
      tick();
      resp_ready = 0;
      tests_run++; if ({req_ready, resp_valid} !== 2'b10) begin tests_failed++; $display("FAIL %s after_resp got %b want 10", nm, {req_ready, resp_valid}); end
   endtask

   task automatic test_misaligned(input string nm, input logic [3:0] op, input logic [31:0] addr);
      int bus_seen;
      do_reset();
      bus_seen = 0;
      req_valid = 1; req_op = op; req_addr = addr; req_wdata = 32'hFFFF_FFFF;
      tick();
      req_valid = 0;
      tests_run++; if ({resp_valid, resp_err} !== 2'b11) begin tests_failed++; $display("FAIL %s resp_cycle1 got %b want 11", nm, {resp_valid, resp_err}); end
      tests_run++; if (resp_data !== 32'h0) begin tests_failed++; $display("FAIL %s resp_data got %h want 0", nm, resp_data); end
      resp_ready = 1;
      for (int c = 0; c < 4; c++) begin
         if (arvalid || awvalid || wvalid) bus_seen++;
         tick();
         resp_ready = 0;
      end
      tests_run++; if (bus_seen !== 0) begin tests_failed++; $display("FAIL %s bus_valid_cycles got %0d want 0", nm, bus_seen); end
      tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL %s back_idle got %b want 1", nm, req_ready); end
   endtask

   task automatic test_sw_skew;
      int aw_hs, w_hs;
      logic got_b;
      do_reset();
      aw_hs = 0; w_hs = 0; got_b = 0;
      req_valid = 1; req_op = LSU_OP_SW; req_addr = 32'h8000_0004; req_wdata = 32'hCAFE_F00D;
      tick();
      req_valid = 0;
      tests_run++; if (wstrb !== 8'hF0) begin tests_failed++; $display("FAIL sw_skew wstrb got %h want f0", wstrb); end
      tests_run++; if (wdata !== 64'hCAFE_F00D_0000_0000) begin tests_failed++; $display("FAIL sw_skew wdata got %h want cafef00d00000000", wdata); end
      for (int c = 1; c <= 20 && !got_b; c++) begin
         wready = 1; awready = (c >= 4);
         if (c == 2) begin
            tests_run++; if ({awvalid, wvalid} !== 2'b10) begin tests_failed++; $display("FAIL sw_skew w_dropped got %b want 10", {awvalid, wvalid}); end
         end
         if (awvalid && awready) aw_hs++;
         if (wvalid && wready) w_hs++;
         if (bready) got_b = 1;
         else tick();
      end
      awready = 0; wready = 0;
      tests_run++; if (got_b !== 1'b1) begin tests_failed++; $display("FAIL sw_skew bready_seen got %b want 1", got_b); end
      tests_run++; if (aw_hs !== 1) begin tests_failed++; $display("FAIL sw_skew aw_handshakes got %0d want 1", aw_hs); end
      tests_run++; if (w_hs !== 1) begin tests_failed++; $display("FAIL sw_skew w_handshakes got %0d want 1", w_hs); end
      bvalid = 1; bresp = 2'b10;
      tick();
      bvalid = 0; bresp = 2'b00;
      tests_run++; if ({resp_valid, resp_err} !== 2'b11) begin tests_failed++; $display("FAIL sw_skew slverr got %b want 11", {resp_valid, resp_err}); end
      resp_ready = 1;
      tick();
      resp_ready = 0;
   endtask

   task automatic test_lw_stall;
      int ar_cycles, araddr_bad, rr_bad, stall_bad;
      do_reset();
      ar_cycles = 0; araddr_bad = 0; rr_bad = 0; stall_bad = 0;
      req_valid = 1; req_op = LSU_OP_LW; req_addr = 32'h8000_0008;
      tick();
      req_valid = 0;
      for (int c = 1; c <= 5; c++) begin
         arready = (c == 5);
         if (arvalid) begin
            ar_cycles++;
            if (araddr !== 32'h8000_0008) araddr_bad++;
         end
         if (req_ready) rr_bad++;
         tick();
      end
      arready = 0;
      tests_run++; if (ar_cycles !== 5) begin tests_failed++; $display("FAIL lw_stall ar_cycles got %0d want 5", ar_cycles); end
      tests_run++; if (araddr_bad !== 0) begin tests_failed++; $display("FAIL lw_stall araddr_unstable got %0d want 0", araddr_bad); end
      tests_run++; if (rready !== 1'b1) begin tests_failed++; $display("FAIL lw_stall rready got %b want 1", rready); end
      rvalid = 1; rdata = 64'hFFFF_FFFF_1234_5678; rresp = 2'b00;
      tick();
      rvalid = 0; rdata = 64'hA5A5_A5A5_A5A5_A5A5;
      // a second request waits on the bus for the whole stall
      req_valid = 1; req_op = LSU_OP_SB; req_addr = 32'h8000_0000; req_wdata = 32'h11;
      for (int c = 0; c < 5; c++) begin
         if (resp_valid !== 1'b1 || resp_data !== 32'h1234_5678 || resp_err !== 1'b0) stall_bad++;
         if (req_ready) rr_bad++;
         tick();
      end
      tests_run++; if (stall_bad !== 0) begin tests_failed++; $display("FAIL lw_stall resp_unstable got %0d want 0", stall_bad); end
      resp_ready = 1;
      if (req_ready) rr_bad++;
      tests_run++; if (rr_bad !== 0) begin tests_failed++; $display("FAIL lw_stall req_ready_early got %0d want 0", rr_bad); end
      tick();
      resp_ready = 0;
      tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL lw_stall req_ready_after got %b want 1", req_ready); end
      tick();
      req_valid = 0;
      tests_run++; if ({awvalid, wstrb} !== {1'b1, 8'h01}) begin
         tests_failed++; $display("FAIL lw_stall next_req got awvalid=%b wstrb=%h want 1/01", awvalid, wstrb); end
   endtask

   task automatic test_reset_mid;
      do_reset();
      req_valid = 1; req_op = LSU_OP_LB; req_addr = 32'h8000_0000;
      tick();
      req_valid = 0; arready = 1;
      tick();
      arready = 0;
      tests_run++; if (rready !== 1'b1) begin tests_failed++; $display("FAIL reset_mid in_rd_data got %b want 1", rready); end
      reset = 1;
      tick();
      tests_run++; if ({arvalid, rready, resp_valid, req_ready} !== 4'b0001) begin
         tests_failed++; $display("FAIL reset_mid after_reset got %b want 0001", {arvalid, rready, resp_valid, req_ready}); end
      reset = 0;
      tick();
      tests_run++; if ({req_ready, resp_valid, arvalid} !== 3'b100) begin
         tests_failed++; $display("FAIL reset_mid idle_hold got %b want 100", {req_ready, resp_valid, arvalid}); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      reset = 1;
      test_reset();
      test_store("sb_lane5", LSU_OP_SB, 32'h8000_0005, 32'h1234_56AB, 8'h20, 64'h0000_AB00_0000_0000, 3'd0);
      test_store("sh_lane2", LSU_OP_SH, 32'h8000_0002, 32'hBEEF_1234, 8'h0C, 64'h0000_0000_1234_0000, 3'd1);
      test_store("sw_lane0", LSU_OP_SW, 32'h8000_0000, 32'hDEAD_BEEF, 8'h0F, 64'h0000_0000_DEAD_BEEF, 3'd2);
      test_load("lb_sign",  LSU_OP_LB,  32'h8000_0003, 64'h0000_0000_8000_0000, 2'b00, 3'd0, 32'hFFFF_FF80, 1'b0);
      test_load("lbu_zero", LSU_OP_LBU, 32'h8000_0003, 64'h0000_0000_8000_0000, 2'b00, 3'd0, 32'h0000_0080, 1'b0);
      test_load("lh_sign",  LSU_OP_LH,  32'h8000_0006, 64'h8001_0000_0000_0000, 2'b00, 3'd1, 32'hFFFF_8001, 1'b0);
      test_load("lhu_zero", LSU_OP_LHU, 32'h8000_0006, 64'h8001_0000_0000_0000, 2'b00, 3'd1, 32'h0000_8001, 1'b0);
      test_load("lw_hi",    LSU_OP_LW,  32'h8000_0004, 64'hDEAD_BEEF_0000_0000, 2'b00, 3'd2, 32'hDEAD_BEEF, 1'b0);
      test_load("lw_rerr",  LSU_OP_LW,  32'h8000_0000, 64'h1111_1111_2222_2222, 2'b10, 3'd2, 32'h0000_0000, 1'b1);
      test_misaligned("lh_mis", LSU_OP_LH, 32'h8000_0001);
      test_misaligned("sw_mis", LSU_OP_SW, 32'h8000_0002);
      test_misaligned("lw_mis", LSU_OP_LW, 32'h8000_0007);
      test_sw_skew();
      test_lw_stall();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/lsu_axi.md
# lsu_axi

Parametrised AXI4 load/store unit for the NPC execute stage, replacing the combinational single-beat LSU. It accepts one load or store request at a time from the EXU, checks alignment, and drives a full AXI4 master handshake (AR/R or AW/W/B) over a configurable data-bus width. It returns a sign- or zero-extended load result, or a store completion, to the WBU through a valid/ready response port with an error flag.

## Interface
- `DATA_W`, 64: AXI data bus width, 32 or 64.
- `XLEN`, 32: register and load-result width.
- `ID_W`, 4: AXI ID width.
- `AXI_ID`, 0: constant ID driven on `awid` and `arid`.

- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` / `req_ready` in / out 1: EXU request handshake.
- `req_op` in 4: `LSU_OP_*` encoding (LB, LBU, LH, LHU, LW, SB, SH, SW).
- `req_addr` in XLEN: effective address (rs1+imm), computed upstream.
- `req_wdata` in XLEN: store data (rs2).
- `resp_valid` / `resp_ready` out / in 1: WBU response handshake.
- `resp_data` out XLEN: load result; 0 for stores.
- `resp_err` out 1: misaligned access, or nonzero RRESP/BRESP.
- `awvalid`/`awready`, `awaddr` XLEN, `awid` ID_W, `awlen` 8, `awsize` 3, `awburst` 2: write-address channel.
- `wvalid`/`wready`, `wdata` DATA_W, `wstrb` DATA_W/8, `wlast` 1: write-data channel.
- `bvalid`/`bready`, `bresp` 2, `bid` ID_W: write-response channel.
- `arvalid`/`arready`, `araddr` XLEN, `arid`, `arlen`, `arsize`, `arburst`: read-address channel.
- `rvalid`/`rready`, `rdata` DATA_W, `rresp` 2, `rlast` 1, `rid` ID_W: read-data channel.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE: `req_ready`=1. On a request handshake, register op, addr, and data, then:
  - misaligned access (H with addr[0]≠0; W with addr[1:0]≠0) goes to RESP with `resp_err`=1 and issues no bus transaction;
  - loads go to RD_ADDR;
  - stores go to WR_REQ.
- RD_ADDR: `arvalid`=1 until `arready`, then RD_DATA. `rready`=1 in RD_DATA; on `rvalid`, capture the result and go to RESP.
- WR_REQ: `awvalid` and `wvalid` are asserted together. Each drops independently once its own ready is seen. Go to WR_RESP when both have completed, in either order or the same cycle. `bready`=1 in WR_RESP; on `bvalid`, go to RESP.
- RESP: hold `resp_valid`, `resp_data`, and `resp_err` stable until `resp_ready`, then return to IDLE. There is no bypass: a new request is accepted no earlier than the cycle after the response handshake.
- Request fields:
  - `lane` = addr[log2(DATA_W/8)-1:0].
  - `awsize`/`arsize` = 0/1/2 for B/H/W.
  - `awlen`=`arlen`=0, `awburst`=`arburst`=INCR (2'b01), `wlast`=1.
  - `awaddr`/`araddr` carry the unmodified byte address.
- Store data: `wstrb` = size mask (0x1/0x3/0xF) << lane. `wdata` = zero-extended data masked to size, << 8·lane.
- Load data: shift `rdata` >> 8·lane, truncate to size, then sign-extend (LB/LH) or zero-extend (LBU/LHU/LW).
- Errors: `resp_err` = (RRESP≠OKAY) or (BRESP≠OKAY), or misaligned. On a read error, `resp_data`=0.
- Reset: every state returns to IDLE. All valids, `resp_data`, and `resp_err` are 0; `req_ready`=1 from the first cycle after reset. A reset mid-transaction abandons the transaction; the interconnect shares the same reset.

## Timing
- AXI outputs are registered; nothing combinational runs from any ready or valid input to any AXI output.
- Load with zero-wait slave: request at cycle 0, `arvalid` at cycle 1, R at cycle 2, `resp_valid` at cycle 3.
- Store with zero-wait slave: request at cycle 0, AW/W at cycle 1, B at cycle 2, `resp_valid` at cycle 3.
- Misaligned access: `resp_valid` at cycle 1.
- `awaddr`, `wdata`, and `wstrb` are stable while the corresponding valid is high.
- `bid` and `rid` are not checked.

## Structure
- Shared package / `defines.v` holds:
  - `LSU_OP_*` codes;
  - the AXI4 bus-width macros;
  - the burst and response constants (`AXI_BURST_INCR`, `AXI_RESP_OKAY`).
- Natural sub-module: `lsu_lane_align`, purely combinational, parameterised by DATA_W. It takes op, lane, store data, and read data, and returns `wstrb`, shifted `wdata`, and the extended load result. The FSM and handshake logic stay in `lsu_axi`.

## Test plan
- DATA_W=64, SB to addr 0x8000_0005, data 0xAB. Expect `wstrb`=0x20 and `wdata`=0x0000_AB00_0000_0000; `resp_valid` 3 cycles after the request; `resp_err`=0.
- LB from 0x8000_0003 with `rdata`=0x0000_0000_8000_0000 → `resp_data`=0xFFFF_FF80. LBU from the same address and data → 0x0000_0080.
- LH at 0x8000_0001 → `resp_err`=1 one cycle after the request; no `arvalid` ever asserted.
- SW to 0x8000_0004. Slave raises `wready` 3 cycles before `awready`. Expect exactly one AW and one W handshake, then `bready`. With BRESP=SLVERR → `resp_err`=1.
- LW with `arready` delayed 4 cycles and `resp_ready` held low for 5 cycles. Expect `araddr` stable throughout, `resp_data` stable while stalled, and `req_ready`=0 until the response handshake.
- Assert `reset` in RD_DATA. Next cycle: IDLE, `arvalid`=`rready`=`resp_valid`=0, `req_ready`=1.
